spi_cmd_ctrl: RTL and testbench

Command sequencer between the SPI byte receiver and the tile-map write port of the snake VGA display. It synchronizes the receiver's chip select into the `clk` domain and captures the three received bytes (command, databyte1, databyte2) at the end of each transaction. It queues the command in a one-entry buffer, decodes it, and drives tile writes over a valid/ready handshake. Commands are a single tile write, a full-screen fill walked by an internal counter, or a score update.

---
 rtl/spi_cmd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: captures SPI command triples into a one-entry buffer and
// turns them into tile writes (single or full-screen fill) or a score update.
module spi_cmd_ctrl #(
   parameter  int GRID_W = 32,
   parameter  int GRID_H = 24,
   localparam int XW     = $clog2(GRID_W),
   localparam int YW     = $clog2(GRID_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic [7:0]    command_rx,
   input  logic [7:0]    databyte1_rx,
   input  logic [7:0]    databyte2_rx,
   output logic          wr_en,
   input  logic          wr_ready,
   output logic [XW-1:0] wr_x,
   output logic [YW-1:0] wr_y,
   output logic [3:0]    wr_data,
   output logic [15:0]   score,
   output logic          busy,
   output logic [7:0]    err_cnt,
   output logic [7:0]    drop_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR,
      S_FILL
   } state_t;

   localparam logic [7:0]    X_LIM  = 8'(GRID_W);
   localparam logic [7:0]    Y_LIM  = 8'(GRID_H);
   localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

   state_t        state_q;
   logic          cs_meta_q, cs_sync_q, cs_prev_q;
   logic          pend_valid_q;
   logic [7:0]    pend_cmd_q, pend_d1_q, pend_d2_q;
   logic          wr_en_q;
   logic [XW-1:0] wr_x_q;
   logic [YW-1:0] wr_y_q;
   logic [3:0]    wr_data_q;
   logic [15:0]   score_q;
   logic [7:0]    err_q, drop_q;

   logic          cs_end;
   logic          pop;

   assign cs_end = cs_prev_q & ~cs_sync_q;
   assign pop    = (state_q == S_IDLE) & pend_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cs_meta_q    <= 1'b0;
         cs_sync_q    <= 1'b0;
         cs_prev_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_cmd_q   <= '0;
         pend_d1_q    <= '0;
         pend_d2_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_x_q       <= '0;
         wr_y_q       <= '0;
         wr_data_q    <= '0;
         score_q      <= '0;
         err_q        <= '0;
         drop_q       <= '0;
      end else begin
         cs_meta_q <= cs;
         cs_sync_q <= cs_meta_q;
         cs_prev_q <= cs_sync_q;

         // A pop and a refill in the same cycle leave the new command buffered.
         if (pop)
            pend_valid_q <= 1'b0;
         if (cs_end) begin
            if (!pend_valid_q || pop) begin
               pend_cmd_q   <= command_rx;
               pend_d1_q    <= databyte1_rx;
               pend_d2_q    <= databyte2_rx;
               pend_valid_q <= 1'b1;
            end else if (drop_q != '1) begin
               drop_q <= drop_q + 8'd1;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (pend_valid_q) begin
                  case (pend_cmd_q[7:4])
                     4'h0: ;
                     4'h1: begin
                        if (pend_d1_q >= X_LIM || pend_d2_q >= Y_LIM) begin
                           if (err_q != '1)
                              err_q <= err_q + 8'd1;
                        end else begin
                           wr_x_q    <= pend_d1_q[XW-1:0];
                           wr_y_q    <= pend_d2_q[YW-1:0];
                           wr_data_q <= pend_cmd_q[3:0];
                           wr_en_q   <= 1'b1;
                           state_q   <= S_WR;
                        end
                     end
                     4'h2: begin
                        wr_x_q    <= '0;
                        wr_y_q    <= '0;
                        wr_data_q <= pend_cmd_q[3:0];
                        wr_en_q   <= 1'b1;
                        state_q   <= S_FILL;
                     end
                     4'h3: score_q <= {pend_d1_q, pend_d2_q};
                     default: begin
                        if (err_q != '1)
                           err_q <= err_q + 8'd1;
                     end
                  endcase
               end
            end
            S_WR: begin
               if (wr_ready) begin
                  wr_en_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_FILL: begin
               // wr_x_q/wr_y_q double as the fill walk counters.
               if (wr_ready) begin
                  if (wr_x_q == X_LAST) begin
                     wr_x_q <= '0;
                     if (wr_y_q == Y_LAST) begin
                        wr_y_q  <= '0;
                        wr_en_q <= 1'b0;
                        state_q <= S_IDLE;
                     end else begin
                        wr_y_q <= wr_y_q + YW'(1);
                     end
                  end else begin
                     wr_x_q <= wr_x_q + XW'(1);
                  end
               end
            end
            default: begin
               wr_en_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_x     = wr_x_q;
   assign wr_y     = wr_y_q;
   assign wr_data  = wr_data_q;
   assign score    = score_q;
   assign err_cnt  = err_q;
   assign drop_cnt = drop_q;
   assign busy     = (state_q != S_IDLE) | pend_valid_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a queue of expected tile writes is filled as
// commands are sent and drained by a monitor on each accepted write.
module tb_spi_cmd_ctrl;

   localparam int GW = 32;
   localparam int GH = 24;
   localparam int XW = 5;
   localparam int YW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          cs;
   logic [7:0]    command_rx, databyte1_rx, databyte2_rx;
   logic          wr_en;
   logic          wr_ready = 1'b0;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic [3:0]    wr_data;
   logic [15:0]   score;
   logic          busy;
   logic [7:0]    err_cnt, drop_cnt;

   spi_cmd_ctrl #(.GRID_W(GW), .GRID_H(GH)) dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .command_rx   (command_rx),
      .databyte1_rx (databyte1_rx),
      .databyte2_rx (databyte2_rx),
      .wr_en        (wr_en),
      .wr_ready     (wr_ready),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_data      (wr_data),
      .score        (score),
      .busy         (busy),
      .err_cnt      (err_cnt),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   int unsigned n_wr  = 0;
   int unsigned exp_wr = 0;
   int          rdy_mode = 0;
   logic [13:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 0 = ready low, 1 = ready high, otherwise toggle every cycle
   always begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       wr_ready = 1'b0;
         1:       wr_ready = 1'b1;
         default: wr_ready = ~wr_ready;
      endcase
   end

   logic        prev_hold = 1'b0;
   logic [13:0] prev_out  = '0;
   always @(negedge clk) begin
      logic [13:0] cur;
      logic [13:0] e;
      cur = {wr_x, wr_y, wr_data};
      if (!reset && prev_hold) begin
         check("hold_wr_en", 32'(wr_en), 1);
         check("hold_outputs", 32'(cur), 32'(prev_out));
      end
      if (!reset && wr_en && wr_ready) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            check("unexpected_write_qsize", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            check("write_xyd", 32'(cur), 32'(e));
         end
      end
      prev_hold = !reset && wr_en && !wr_ready;
      prev_out  = cur;
   end

   task automatic start_cmd(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
      @(posedge clk);
      #1;
      command_rx   = c;
      databyte1_rx = d1;
      databyte2_rx = d2;
      cs           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cs = 1'b0;
   endtask

   // Returns #1 after E4, the edge on which the command is popped when idle.
   task automatic send_cmd(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
      start_cmd(c, d1, d2);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int x, input int y, input logic [3:0] d);
      exp_q.push_back({5'(x), 5'(y), d});
      exp_wr++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset = 1'b1;
      cs = 1'b0;
      command_rx = '0;
      databyte1_rx = '0;
      databyte2_rx = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // cs held low after reset: no false capture
      repeat (6) begin
         @(posedge clk);
         #1;
         check("rst_wr_en", 32'(wr_en), 0);
      end
      check("rst_busy", 32'(busy), 0);
      check("rst_xyd", 32'({wr_x, wr_y, wr_data}), 0);
      check("rst_score", 32'(score), 0);
      check("rst_err", 32'(err_cnt), 0);
      check("rst_drop", 32'(drop_cnt), 0);

      // single WRITE with exact latency
      rdy_mode = 1;
      push_wr(3, 2, 4'h5);
      start_cmd(8'h15, 8'h03, 8'h02);
      repeat (3) @(posedge clk);
      #1;
      check("e3_wr_en", 32'(wr_en), 0);
      check("e3_busy", 32'(busy), 1);
      @(posedge clk);
      #1;
      check("e4_wr_en", 32'(wr_en), 1);
      check("e4_wr_x", 32'(wr_x), 3);
      check("e4_wr_y", 32'(wr_y), 2);
      check("e4_wr_data", 32'(wr_data), 5);
      @(posedge clk);
      #1;
      check("e5_wr_en", 32'(wr_en), 0);
      check("e5_busy", 32'(busy), 0);
      check("write1_count", n_wr, exp_wr);

      // WRITE stalled by wr_ready low
      rdy_mode = 0;
      push_wr(10, 23, 4'hA);
      send_cmd(8'h1A, 8'd10, 8'd23);
      for (int i = 0; i < 5; i++) begin
         check("stall_wr_en", 32'(wr_en), 1);
         @(posedge clk);
         #1;
      end
      check("stall_no_accept", n_wr, exp_wr - 1);
      rdy_mode = 1;
      @(posedge clk);
      #1;
      check("stall_release_wr_en", 32'(wr_en), 0);
      check("stall_count", n_wr, exp_wr);

      // out-of-range WRITEs and boundary in-range WRITE
      send_cmd(8'h1F, 8'd32, 8'd0);
      check("oor_x_err", 32'(err_cnt), 1);
      check("oor_x_wr_en", 32'(wr_en), 0);
      send_cmd(8'h1F, 8'd0, 8'd24);
      check("oor_y_err", 32'(err_cnt), 2);
      push_wr(31, 23, 4'h3);
      send_cmd(8'h13, 8'd31, 8'd23);
      repeat (2) @(posedge clk);
      #1;
      check("corner_count", n_wr, exp_wr);
      check("corner_err", 32'(err_cnt), 2);
      send_cmd(8'h05, 8'hAA, 8'h55);
      check("nop_err", 32'(err_cnt), 2);
      check("nop_busy", 32'(busy), 0);

      // FILL with toggling ready, two commands sent mid-fill
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            push_wr(x, y, 4'h7);
      rdy_mode = 2;
      send_cmd(8'h27, 8'h00, 8'h00);
      send_cmd(8'h30, 8'h12, 8'h34);
      send_cmd(8'h3F, 8'hAB, 8'hCD);
      check("fill_drop", 32'(drop_cnt), 1);
      cnt = 0;
      while ((busy || wr_en) && cnt < 4000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("fill_done_in_time", 32'(cnt < 4000), 1);
      check("fill_count", n_wr, exp_wr);
      check("fill_queue_empty", 32'(exp_q.size()), 0);
      check("fill_score", 32'(score), 32'h1234);
      check("fill_drop_after", 32'(drop_cnt), 1);

      // FILL at full rate: wr_en high for exactly GW*GH cycles
      rdy_mode = 1;
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            push_wr(x, y, 4'hC);
      send_cmd(8'h2C, 8'h00, 8'h00);
      cnt = 0;
      while (wr_en === 1'b1 && cnt < 2000) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      check("fill_run_len", 32'(cnt), GW * GH);
      check("fill2_count", n_wr, exp_wr);

      // reset on fill write 100
      for (int k = 0; k < 99; k++)
         push_wr(k % GW, k / GW, 4'h3);
      send_cmd(8'h23, 8'h00, 8'h00);
      repeat (99) @(posedge clk);
      #1;
      check("pre_rst_wr_en", 32'(wr_en), 1);
      check("pre_rst_pos", 32'({wr_x, wr_y}), 32'({5'd3, 5'd3}));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_wr_en", 32'(wr_en), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_score", 32'(score), 0);
      check("mid_rst_err", 32'(err_cnt), 0);
      check("mid_rst_drop", 32'(drop_cnt), 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_wr_en", 32'(wr_en), 0);
      check("post_rst_count", n_wr, exp_wr);
      check("post_rst_queue", 32'(exp_q.size()), 0);

      // err_cnt saturation
      for (int i = 0; i < 254; i++)
         send_cmd(8'h90, 8'h00, 8'h00);
      check("err_254", 32'(err_cnt), 254);
      send_cmd(8'h90, 8'h00, 8'h00);
      check("err_255", 32'(err_cnt), 255);
      for (int i = 0; i < 45; i++)
         send_cmd(8'h90, 8'h00, 8'h00);
      check("err_sat", 32'(err_cnt), 255);
      check("err_sat_drop", 32'(drop_cnt), 0);
      check("err_sat_no_writes", n_wr, exp_wr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
